// File: rtl/dso_wave_ddr_reader.sv
// AXI4 read master: fetches a stored DSO frame in credit-limited bursts, buffers the
// beats in a FIFO and unpacks them LSB-first into a SAMPLE_W-wide sample stream.
module dso_wave_ddr_reader #(
    parameter int AXI_ADDR_W = 28,
    parameter int AXI_DATA_W = 256,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int SAMPLE_W   = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] base_addr,
    input  logic [15:0]           num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [AXI_ADDR_W-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [AXI_DATA_W-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [SAMPLE_W-1:0]   smp_data,
    output logic                  smp_valid,
    input  logic                  smp_ready
);
    localparam int NSMP  = AXI_DATA_W / SAMPLE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SW    = (NSMP > 1) ? $clog2(NSMP) : 1;
    localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BYTES = AXI_DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t state_q;

    logic [AXI_ADDR_W-1:0] addr_q;
    logic [15:0]           rem_q, total_q, rcv_q;
    logic [BW-1:0]         bcnt_q;
    logic [AW:0]           cnt_q, outst_q;
    logic [AW-1:0]         wr_q, rd_q;
    logic [AXI_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AXI_DATA_W-1:0] ubeat_q;
    logic [SW-1:0]         uidx_q;
    logic [7:0]            arlen_q;
    logic                  arvalid_q, busy_q, done_q, err_q, uvalid_q;

    logic [16:0] len, free;
    logic        credit_ok, ar_hs, rbeat, full, push, take, ulast, pop, exp_last, all_rcv;

    assign len       = (rem_q > 16'(BURST_LEN)) ? 17'(BURST_LEN) : {1'b0, rem_q};
    assign free      = 17'(FIFO_DEPTH) - 17'(cnt_q) - 17'(outst_q);
    assign credit_ok = free >= len;
    assign ar_hs     = arvalid_q && axi_arready;
    assign rbeat     = axi_rvalid && busy_q;
    assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign push      = rbeat && !full;
    assign take      = uvalid_q && smp_ready;
    assign ulast     = uidx_q == SW'(NSMP - 1);
    assign pop       = (cnt_q != '0) && (!uvalid_q || (take && ulast));
    // Every burst except the last is full length, so burst ends are found by counting.
    assign exp_last  = (bcnt_q == BW'(BURST_LEN - 1)) || (rcv_q == total_q - 16'd1);
    assign all_rcv   = rcv_q == total_q;

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_q] <= axi_rdata;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            total_q   <= '0;
            rcv_q     <= '0;
            bcnt_q    <= '0;
            cnt_q     <= '0;
            outst_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            ubeat_q   <= '0;
            uidx_q    <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            uvalid_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            outst_q <= outst_q + (ar_hs ? (AW+1)'(len) : '0)
                       - (AW+1)'(rbeat && (outst_q != '0));

            if (rbeat) begin
                rcv_q  <= rcv_q + 16'd1;
                bcnt_q <= exp_last ? '0 : bcnt_q + 1'b1;
                if ((axi_rresp != 2'b00) || (axi_rlast != exp_last) || all_rcv) err_q <= 1'b1;
            end

            if (pop) begin
                ubeat_q  <= mem_q[rd_q];
                uvalid_q <= 1'b1;
                uidx_q   <= '0;
            end else if (take) begin
                ubeat_q <= ubeat_q >> SAMPLE_W;
                uidx_q  <= uidx_q + 1'b1;
                if (ulast) uvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: if (start) begin
                    addr_q  <= base_addr;
                    rem_q   <= num_beats;
                    total_q <= num_beats;
                    rcv_q   <= '0;
                    bcnt_q  <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= (num_beats == 16'd0) ? DONE : REQ;
                    done_q  <= (num_beats == 16'd0);
                end
                REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        addr_q    <= addr_q + AXI_ADDR_W'(len) * AXI_ADDR_W'(BYTES);
                        rem_q     <= rem_q - len[15:0];
                        if (rem_q == len[15:0]) state_q <= DRAIN;
                    end else if (!arvalid_q && credit_ok) begin
                        arvalid_q <= 1'b1;
                        arlen_q   <= 8'(len - 17'd1);
                    end
                end
                DRAIN: if (all_rcv && (cnt_q == '0) && !uvalid_q) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Credits reserve FIFO room for every requested beat, so a beat can never meet a full FIFO.
    assert property (@(posedge sys_clk) disable iff (!sys_rst_n) !(axi_rvalid && busy_q && full));

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = busy_q;
    assign smp_data    = ubeat_q[SAMPLE_W-1:0];
    assign smp_valid   = uvalid_q;
endmodule

// File: tb/tb_dso_wave_ddr_reader.sv
// Directed bench for dso_wave_ddr_reader: behavioural AXI read slave, sample monitor,
// and a linear sequence of frame scenarios with hand-derived expectations.
module tb_dso_wave_ddr_reader;
    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         start = 1'b0;
    logic [27:0]  base_addr = '0;
    logic [15:0]  num_beats = '0;
    logic         busy, done, err;
    logic [27:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready = 1'b1;
    logic [255:0] axi_rdata = '0;
    logic [1:0]   axi_rresp = '0;
    logic         axi_rlast = 1'b0;
    logic         axi_rvalid = 1'b0;
    logic         axi_rready;
    logic [7:0]   smp_data;
    logic         smp_valid;
    logic         smp_ready = 1'b1;

    dso_wave_ddr_reader dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .base_addr(base_addr),
        .num_beats(num_beats), .busy(busy), .done(done), .err(err),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0, failures = 0;

    // Stored waveform content: one byte per byte address.
    function automatic logic [7:0] byte_at(input logic [27:0] a);
        return a[7:0] + 8'd37 * a[15:8] + 8'd91 * a[23:16] + {4'h0, a[27:24]};
    endfunction

    function automatic logic [255:0] beat_at(input logic [27:0] a);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) d[k*8 +: 8] = byte_at(a + 28'(k));
        return d;
    endfunction

    // AXI read slave
    logic [27:0] arq_addr[$];
    logic [7:0]  arq_len[$];
    logic [27:0] rb_addr = '0;
    int          rb_left = 0;
    bit          rb_act = 0;
    int          slv_beats = 0, bad_beat = -1, ar_cnt = 0;
    bit          drop_last = 0;
    logic [27:0] ar_log_addr[8];
    logic [7:0]  ar_log_len[8];

    initial begin : slave
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                arq_addr.delete();
                arq_len.delete();
                rb_act = 0;
            end else begin
                if (axi_arvalid && axi_arready) begin
                    arq_addr.push_back(axi_araddr);
                    arq_len.push_back(axi_arlen);
                    if (ar_cnt < 8) begin
                        ar_log_addr[ar_cnt] = axi_araddr;
                        ar_log_len[ar_cnt]  = axi_arlen;
                    end
                    ar_cnt++;
                end
                if (axi_rvalid && axi_rready) begin
                    slv_beats++;
                    rb_addr = rb_addr + 28'd32;
                    rb_left--;
                    if (rb_left == 0) rb_act = 0;
                end
                if (!rb_act && arq_addr.size() > 0) begin
                    rb_addr = arq_addr.pop_front();
                    rb_left = int'(arq_len.pop_front()) + 1;
                    rb_act  = 1;
                end
            end
            #1;
            axi_rvalid = rb_act;
            axi_rdata  = rb_act ? beat_at(rb_addr) : '0;
            axi_rresp  = (rb_act && slv_beats == bad_beat) ? 2'b10 : 2'b00;
            axi_rlast  = rb_act && (rb_left == 1) && !drop_last;
        end
    end

    // Sample monitor: address-order data and hold stability while stalled
    logic [27:0] exp_base = '0;
    int          smp_cnt = 0, mon_err = 0, done_cnt = 0;
    bit          hold_prev = 0;
    logic [7:0]  prev_data = '0;

    initial begin : monitor
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                hold_prev = 0;
            end else begin
                if (hold_prev && (!smp_valid || smp_data !== prev_data)) mon_err++;
                if (smp_valid && smp_ready) begin
                    if (smp_data !== byte_at(exp_base + 28'(smp_cnt))) mon_err++;
                    smp_cnt++;
                end
                hold_prev = smp_valid && !smp_ready;
                prev_data = smp_data;
                if (done) done_cnt++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic new_frame(input logic [27:0] b);
        exp_base = b; smp_cnt = 0; mon_err = 0; done_cnt = 0; ar_cnt = 0; slv_beats = 0;
    endtask

    task automatic pulse_start(input logic [27:0] b, input logic [15:0] n);
        @(negedge sys_clk);
        start = 1'b1; base_addr = b; num_beats = n;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 4000) begin
            @(negedge sys_clk);
            t++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin : main
        cyc(3);
        chk("reset_outputs", 64'({busy, done, err, axi_arvalid, axi_rready, smp_valid,
                                 axi_araddr, axi_arlen, smp_data}), 64'd0);
        sys_rst_n = 1'b1;
        cyc(2);

        // 40 beats -> bursts of 16,16,8; a start mid-frame must be ignored
        new_frame(28'h0001000);
        pulse_start(28'h0001000, 16'd40);
        cyc(50);
        pulse_start(28'h5550000, 16'd3);
        wait_done("t1_done");
        cyc(1);
        chk("t1_ar_cnt", 64'(ar_cnt), 64'd3);
        chk("t1_ar0_addr", 64'(ar_log_addr[0]), 64'h0001000);
        chk("t1_ar0_len", 64'(ar_log_len[0]), 64'd15);
        chk("t1_ar1_addr", 64'(ar_log_addr[1]), 64'h0001200);
        chk("t1_ar1_len", 64'(ar_log_len[1]), 64'd15);
        chk("t1_ar2_addr", 64'(ar_log_addr[2]), 64'h0001400);
        chk("t1_ar2_len", 64'(ar_log_len[2]), 64'd7);
        chk("t1_beats", 64'(slv_beats), 64'd40);
        chk("t1_samples", 64'(smp_cnt), 64'd1280);
        chk("t1_data", 64'(mon_err), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Downstream stall after 10 samples: credits stop the third burst
        new_frame(28'h0002000);
        pulse_start(28'h0002000, 16'd40);
        begin
            int t = 0;
            while (smp_cnt < 10 && t < 500) begin
                @(negedge sys_clk);
                t++;
            end
        end
        smp_ready = 1'b0;
        cyc(200);
        chk("t2_held_samples", 64'(smp_cnt), 64'd10);
        chk("t2_ar_cnt", 64'(ar_cnt), 64'd2);
        chk("t2_arvalid_low", 64'(axi_arvalid), 64'd0);
        chk("t2_beats_in", 64'(slv_beats), 64'd32);
        chk("t2_smp_valid", 64'(smp_valid), 64'd1);
        smp_ready = 1'b1;
        wait_done("t2_done");
        cyc(1);
        chk("t2_samples", 64'(smp_cnt), 64'd1280);
        chk("t2_data", 64'(mon_err), 64'd0);
        chk("t2_ar_total", 64'(ar_cnt), 64'd3);

        // Zero-length frame
        new_frame(28'h0);
        pulse_start(28'h0, 16'd0);
        chk("t3_done_now", 64'({done, busy}), 64'b11);
        cyc(1);
        chk("t3_done_gone", 64'({done, busy}), 64'b00);
        chk("t3_no_ar", 64'(ar_cnt), 64'd0);

        // Bad RRESP on beat 5: err sticky, data still delivered
        bad_beat = 5;
        new_frame(28'h0003000);
        pulse_start(28'h0003000, 16'd40);
        cyc(30);
        chk("t4_err_mid", 64'(err), 64'd1);
        wait_done("t4_done");
        cyc(1);
        bad_beat = -1;
        chk("t4_samples", 64'(smp_cnt), 64'd1280);
        chk("t4_data", 64'(mon_err), 64'd0);
        cyc(5);
        chk("t4_err_sticky", 64'(err), 64'd1);
        new_frame(28'h0);
        pulse_start(28'h0, 16'd0);
        chk("t4_err_cleared", 64'(err), 64'd0);
        cyc(2);

        // Missing RLAST on the final beat
        drop_last = 1;
        new_frame(28'h0004000);
        pulse_start(28'h0004000, 16'd2);
        wait_done("t4b_done");
        cyc(1);
        drop_last = 0;
        chk("t4b_err", 64'(err), 64'd1);
        chk("t4b_samples", 64'(smp_cnt), 64'd64);

        // AR stall with address wrap at the top of the space
        axi_arready = 1'b0;
        new_frame(28'hFFFFE00);
        pulse_start(28'hFFFFE00, 16'd20);
        cyc(1);
        for (int i = 0; i < 7; i++) begin
            chk("t5_arvalid_hold", 64'(axi_arvalid), 64'd1);
            chk("t5_araddr_hold", 64'(axi_araddr), 64'hFFFFE00);
            chk("t5_arlen_hold", 64'(axi_arlen), 64'd15);
            cyc(1);
        end
        axi_arready = 1'b1;
        wait_done("t5_done");
        cyc(1);
        chk("t5_ar_cnt", 64'(ar_cnt), 64'd2);
        chk("t5_ar1_wrap", 64'(ar_log_addr[1]), 64'h0000000);
        chk("t5_ar1_len", 64'(ar_log_len[1]), 64'd3);
        chk("t5_samples", 64'(smp_cnt), 64'd640);
        chk("t5_data", 64'(mon_err), 64'd0);

        // Reset mid-frame, then a clean frame
        new_frame(28'h0005000);
        pulse_start(28'h0005000, 16'd40);
        cyc(60);
        chk("t6_busy_before", 64'(busy), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 64'({busy, done, err, axi_arvalid, axi_rready, smp_valid,
                                  axi_araddr, axi_arlen, smp_data}), 64'd0);
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(3);
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        new_frame(28'h0006000);
        pulse_start(28'h0006000, 16'd8);
        wait_done("t6_done");
        cyc(1);
        chk("t6_ar_cnt", 64'(ar_cnt), 64'd1);
        chk("t6_ar_len", 64'(ar_log_len[0]), 64'd7);
        chk("t6_samples", 64'(smp_cnt), 64'd256);
        chk("t6_data", 64'(mon_err), 64'd0);
        chk("t6_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
